// File: rtl/inst_fetch_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_mem_if
//  Description : Handshake bundle for inst_fetch_mem: program-load stream,
//                fetch request, instruction output and load progress count.
//                The slave modport is the memory side, master the client.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_mem_if #(
    parameter int DEPTH = 256
);
    localparam int c_cw = $clog2(DEPTH) + 1;

    // Program-load stream
    logic            load_start;
    logic            load_valid;
    logic [31:0]     load_data;
    logic            load_last;
    logic            load_ready;

    // Fetch request
    logic            fetch_valid;
    logic [31:0]     fetch_base;
    logic [31:0]     fetch_off;
    logic            fetch_ready;

    // Instruction output
    logic            inst_valid;
    logic [31:0]     inst_out;
    logic            inst_fault;
    logic            inst_ready;

    // Load progress
    logic [c_cw-1:0] loaded_words;

    modport slave (
        input  load_start, load_valid, load_data, load_last,
        output load_ready,
        input  fetch_valid, fetch_base, fetch_off,
        output fetch_ready,
        output inst_valid, inst_out, inst_fault,
        input  inst_ready,
        output loaded_words
    );

    modport master (
        output load_start, load_valid, load_data, load_last,
        input  load_ready,
        output fetch_valid, fetch_base, fetch_off,
        input  fetch_ready,
        input  inst_valid, inst_out, inst_fault,
        output inst_ready,
        input  loaded_words
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_mem.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_mem
//  Description : Instruction memory with a program-load port and a
//                single-cycle fetch port behind a one-entry output register.
//                LOAD state streams words in from address 0; RUN state serves
//                fetches at (fetch_base + fetch_off) >> 2.
//                Optional macro INST_FETCH_MEM_FAULT_EN enables fault
//                detection (misaligned, beyond DEPTH, beyond loaded words),
//                returning NOP_WORD on a faulted fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_mem #(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  wire logic          clk,
    input  wire logic          reset,
    inst_fetch_mem_if.slave    bus
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    // DEPTH is a power of two, so the last word index is all ones
    localparam logic [c_aw-1:0] c_wptr_last = {c_aw{1'b1}};

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [c_aw-1:0]   r_wptr;
    logic [c_cw-1:0]   r_loaded;
    logic [31:0]       r_mem [DEPTH];

    logic              r_inst_valid;
    logic [31:0]       r_inst_out;
    logic              r_inst_fault;

    logic              w_load_ready;
    logic              w_fetch_ready;
    logic              w_load_beat;
    logic              w_fetch_acc;
    logic              w_restart;

    logic [31:0]       w_addr;
    logic [c_aw-1:0]   w_idx;
    logic              w_fault;
    logic [31:0]       w_fetch_data;

    // Byte address wraps modulo 2^32; the low c_aw bits of the word index
    // select the memory entry
    assign w_addr = bus.fetch_base + bus.fetch_off;
    assign w_idx  = w_addr[c_aw+1:2];

`ifdef INST_FETCH_MEM_FAULT_EN
    logic w_misaligned;
    logic w_beyond_depth;
    logic w_beyond_loaded;

    // Out-of-range if any index bit above the memory size is set, or if the
    // in-range index points past the words loaded so far
    assign w_misaligned    = (w_addr[1:0] != 2'b00);
    assign w_beyond_depth  = |w_addr[31:c_aw+2];
    assign w_beyond_loaded = ({1'b0, w_idx} >= r_loaded);
    assign w_fault         = w_misaligned | w_beyond_depth | w_beyond_loaded;
    assign w_fetch_data    = w_fault ? NOP_WORD : r_mem[w_idx];
`else
    logic w_unused;

    // Without fault detection the byte offset and upper index bits are
    // ignored so the index wraps modulo DEPTH
    assign w_fault      = 1'b0;
    assign w_fetch_data = r_mem[w_idx];
    assign w_unused     = ^{w_addr[31:c_aw+2], w_addr[1:0], NOP_WORD};
`endif

    // Handshake qualifiers; a restart in RUN has priority over any fetch
    assign w_load_beat = bus.load_valid & w_load_ready;
    assign w_fetch_acc = bus.fetch_valid & w_fetch_ready;
    assign w_restart   = (r_state == ST_RUN) & bus.load_start;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake-ready decode
    always_comb begin
        w_state_nxt   = r_state;
        w_load_ready  = 1'b0;
        w_fetch_ready = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_load_ready = 1'b1;
                // Leave on an explicit last beat or when the memory is full
                if (bus.load_valid && (bus.load_last || (r_wptr == c_wptr_last))) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // One-entry output register: accept when empty or draining
                w_fetch_ready = !bus.load_start && (!r_inst_valid || bus.inst_ready);
                if (bus.load_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // Load write pointer and loaded-word count, restarted on a new load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr   <= '0;
            r_loaded <= '0;
        end else if (w_restart) begin
            r_wptr   <= '0;
            r_loaded <= '0;
        end else if (w_load_beat) begin
            r_wptr   <= r_wptr + 1'b1;
            r_loaded <= r_loaded + 1'b1;
        end
    end

    // Instruction storage; contents survive reset and reload requests
    always_ff @(posedge clk) begin
        if (w_load_beat) begin
            r_mem[r_wptr] <= bus.load_data;
        end
    end

    // Output register: load on accepted fetch, hold under backpressure,
    // empty on consumer accept or when a reload drops the pending word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inst_valid <= 1'b0;
            r_inst_out   <= '0;
            r_inst_fault <= 1'b0;
        end else if (w_restart) begin
            r_inst_valid <= 1'b0;
        end else if (w_fetch_acc) begin
            r_inst_valid <= 1'b1;
            r_inst_out   <= w_fetch_data;
            r_inst_fault <= w_fault;
        end else if (bus.inst_ready) begin
            r_inst_valid <= 1'b0;
        end
    end

    assign bus.load_ready   = w_load_ready;
    assign bus.fetch_ready  = w_fetch_ready;
    assign bus.inst_valid   = r_inst_valid;
    assign bus.inst_out     = r_inst_out;
    assign bus.inst_fault   = r_inst_fault;
    assign bus.loaded_words = r_loaded;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_mem
//  Description : Directed self-checking bench for inst_fetch_mem (DEPTH=16).
//                Expected fetch results come from a reference model of the
//                memory and are queued when a fetch is accepted, then
//                compared when the instruction register presents them.
//                Fault expectations follow INST_FETCH_MEM_FAULT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_mem;

    localparam int c_depth = 16;

    typedef struct packed {
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic clk;
    logic reset;

    inst_fetch_mem_if #(.DEPTH(c_depth)) bus ();

    inst_fetch_mem #(
        .DEPTH    (c_depth),
        .NOP_WORD (32'h0000_0013)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    exp_t        q[$];
    logic [31:0] m_mem [c_depth];
    int          m_loaded = 0;
    bit          m_run    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] b, input logic [31:0] o);
        exp_t        e;
        logic [31:0] a;
        logic [29:0] idx;
        a   = b + o;
        idx = a[31:2];
`ifdef INST_FETCH_MEM_FAULT_EN
        e.fault = (a[1:0] != 2'b00) || (idx >= 30'(c_depth)) || (idx >= 30'(m_loaded));
        e.data  = e.fault ? 32'h0000_0013 : m_mem[idx[3:0]];
`else
        e.fault = 1'b0;
        e.data  = m_mem[idx[3:0]];
`endif
        return e;
    endfunction

    // One clock cycle: inputs already driven after a falling edge; sample
    // and score, advance the model, then return at the next falling edge
    task automatic tick();
        bit ev;
        bit efr;
        #1;
        ev  = (q.size() != 0);
        efr = m_run && !bus.load_start && (!ev || bus.inst_ready);
        chk("inst_valid",   32'(bus.inst_valid),   32'(ev));
        chk("load_ready",   32'(bus.load_ready),   32'(!m_run));
        chk("fetch_ready",  32'(bus.fetch_ready),  32'(efr));
        chk("loaded_words", 32'(bus.loaded_words), 32'(m_loaded));
        if (ev) begin
            chk("sb_inst_out",   bus.inst_out,          q[0].data);
            chk("sb_inst_fault", 32'(bus.inst_fault),   32'(q[0].fault));
        end
        if (m_run) begin
            if (bus.load_start) begin
                q.delete();
                m_run    = 1'b0;
                m_loaded = 0;
            end else begin
                if (ev && bus.inst_ready) void'(q.pop_front());
                if (bus.fetch_valid && efr) q.push_back(model(bus.fetch_base, bus.fetch_off));
            end
        end else if (bus.load_valid) begin
            m_mem[m_loaded % c_depth] = bus.load_data;
            m_loaded++;
            if (bus.load_last || (m_loaded == c_depth)) m_run = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic load_beat(input logic [31:0] d, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = last;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] b, input logic [31:0] o);
        bus.fetch_valid = 1'b1;
        bus.fetch_base  = b;
        bus.fetch_off   = o;
        tick();
    endtask

    initial begin
        reset           = 1'b0;
        bus.load_start  = 1'b0;
        bus.load_valid  = 1'b0;
        bus.load_data   = '0;
        bus.load_last   = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.fetch_base  = '0;
        bus.fetch_off   = '0;
        bus.inst_ready  = 1'b1;

        // Reset state, observed before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_inst_valid",  32'(bus.inst_valid),   32'd0);
        chk("rst_inst_out",    bus.inst_out,          32'd0);
        chk("rst_inst_fault",  32'(bus.inst_fault),   32'd0);
        chk("rst_loaded",      32'(bus.loaded_words), 32'd0);
        chk("rst_load_ready",  32'(bus.load_ready),   32'd1);
        chk("rst_fetch_ready", 32'(bus.fetch_ready),  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Load four words, last on the fourth
        load_beat(32'h11, 1'b0);
        load_beat(32'h22, 1'b0);
        load_beat(32'h33, 1'b0);
        load_beat(32'h44, 1'b1);
        chk("load_count",     32'(bus.loaded_words), 32'd4);
        chk("load_ready_run", 32'(bus.load_ready),   32'd0);

        // Single fetch base=4 off=4 -> word 2
        fetch(32'd4, 32'd4);
        chk("f44_valid", 32'(bus.inst_valid), 32'd1);
        chk("f44_out",   bus.inst_out,        32'h33);
        chk("f44_fault", 32'(bus.inst_fault), 32'd0);

        // Back-to-back fetches, one per cycle
        fetch(32'd0, 32'd0);
        chk("b2b_0", bus.inst_out, 32'h11);
        fetch(32'd0, 32'd4);
        chk("b2b_1", bus.inst_out, 32'h22);
        fetch(32'd0, 32'd8);
        chk("b2b_2", bus.inst_out, 32'h33);
        bus.fetch_valid = 1'b0;
        tick();

        // Backpressure: output held while the consumer stalls
        bus.inst_ready = 1'b0;
        fetch(32'd0, 32'd12);
        for (int i = 0; i < 3; i++) begin
            fetch(32'd0, 32'd0);
            chk("bp_hold_out", bus.inst_out, 32'h44);
            chk("bp_fready",   32'(bus.fetch_ready), 32'd0);
        end
        bus.inst_ready = 1'b1;
        fetch(32'd0, 32'd0);
        chk("bp_release", bus.inst_out, 32'h11);
        bus.fetch_valid = 1'b0;
        tick();

        // Misaligned / out-of-loaded-range fetches
        fetch(32'd2, 32'd0);
`ifdef INST_FETCH_MEM_FAULT_EN
        chk("mis_out",   bus.inst_out,        32'h0000_0013);
        chk("mis_fault", 32'(bus.inst_fault), 32'd1);
        fetch(32'd16, 32'd0);
        chk("oor_fault", 32'(bus.inst_fault), 32'd1);
        chk("oor_out",   bus.inst_out,        32'h0000_0013);
`else
        chk("mis_out",   bus.inst_out,        32'h11);
        chk("mis_fault", 32'(bus.inst_fault), 32'd0);
`endif
        bus.fetch_valid = 1'b0;
        tick();

        // Collision: load_start beats a fetch and drops the pending word
        bus.inst_ready = 1'b0;
        fetch(32'd0, 32'd4);
        chk("col_pending", bus.inst_out, 32'h22);
        bus.load_start = 1'b1;
        fetch(32'd0, 32'd8);
        bus.load_start  = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.inst_ready  = 1'b1;
        chk("col_load_ready", 32'(bus.load_ready), 32'd1);
        chk("col_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("col_loaded",     32'(bus.loaded_words), 32'd0);

        // Partial reload, then asynchronous reset between edges
        load_beat(32'hA1, 1'b0);
        load_beat(32'hA2, 1'b0);
        chk("mid_loaded", 32'(bus.loaded_words), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("areset_valid",  32'(bus.inst_valid),   32'd0);
        chk("areset_out",    bus.inst_out,          32'd0);
        chk("areset_fault",  32'(bus.inst_fault),   32'd0);
        chk("areset_loaded", 32'(bus.loaded_words), 32'd0);
        q.delete();
        m_loaded = 0;
        m_run    = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Full reload without load_last: RUN after exactly DEPTH beats
        for (int i = 0; i < c_depth; i++) begin
            if (i == c_depth - 1) chk("full_ready_15", 32'(bus.load_ready), 32'd1);
            load_beat(32'h100 + 32'(i), 1'b0);
        end
        chk("full_ready_16", 32'(bus.load_ready),   32'd0);
        chk("full_loaded",   32'(bus.loaded_words), 32'd16);

        fetch(32'd0, 32'd0);
        chk("reload_word0", bus.inst_out, 32'h100);
        fetch(32'd0, 32'd60);
        chk("reload_word15", bus.inst_out, 32'h10F);
        fetch(32'd0, 32'd64);
`ifdef INST_FETCH_MEM_FAULT_EN
        chk("depth_fault", 32'(bus.inst_fault), 32'd1);
`else
        chk("depth_wrap", bus.inst_out, 32'h100);
`endif
        bus.fetch_valid = 1'b0;
        tick();
        tick();
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch_mem.md
INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning number of 32-bit instruction words (power of two, 16..4096).
REQ-002 The block SHALL have parameter NOP_WORD, default 32'h00000013, meaning the word returned on a faulted fetch.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-005 The block SHALL have port load_start, input, 1 bit, a request to (re)enter program-load mode.
REQ-006 The block SHALL have port load_valid, input, 1 bit, indicating the load beat is valid.
REQ-007 The block SHALL have port load_data, input, 32 bits, the instruction word being loaded.
REQ-008 The block SHALL have port load_last, input, 1 bit, marking the final load beat.
REQ-009 The block SHALL have port load_ready, output, 1 bit, indicating the block accepts load beats.
REQ-010 The block SHALL have port fetch_valid, input, 1 bit, indicating a fetch request.
REQ-011 The block SHALL have port fetch_base, input, 32 bits, the byte-address base (pc).
REQ-012 The block SHALL have port fetch_off, input, 32 bits, the byte offset added to fetch_base.
REQ-013 The block SHALL have port fetch_ready, output, 1 bit, indicating the block accepts a fetch.
REQ-014 The block SHALL have port inst_valid, output, 1 bit, indicating the output instruction is valid.
REQ-015 The block SHALL have port inst_out, output, 32 bits, the fetched instruction.
REQ-016 The block SHALL have port inst_fault, output, 1 bit, asserted when the fetch is misaligned or out of range.
REQ-017 The block SHALL have port inst_ready, input, 1 bit, indicating the consumer accepts the instruction.
REQ-018 The block SHALL have port loaded_words, output, clog2(DEPTH)+1 bits, the count of words loaded so far.

Function
REQ-019 The FSM SHALL have two states, LOAD and RUN; it SHALL enter LOAD on reset.
REQ-020 In LOAD, load_ready SHALL be 1 and fetch_ready SHALL be 0.
REQ-021 A load beat (load_valid&load_ready) SHALL write load_data to mem[wptr], then increment wptr and loaded_words.
REQ-022 The FSM SHALL go LOAD->RUN on the accepted beat having load_last=1, or on the accepted beat where wptr=DEPTH-1; further beats in that state are not accepted.
REQ-023 In RUN, load_start=1 SHALL move the FSM to LOAD next cycle, clear wptr, loaded_words and inst_valid, and drop any pending output.
REQ-024 If load_start and fetch_valid are both 1 in RUN, load_start SHALL win and the fetch SHALL NOT be accepted (fetch_ready=0 that cycle).
REQ-025 In RUN, fetch_ready SHALL equal !inst_valid | inst_ready (a one-entry output register).
REQ-026 Byte address SHALL be (fetch_base+fetch_off) mod 2^32, and word index SHALL be addr[31:2].
REQ-027 An accepted fetch at edge N SHALL present inst_valid=1 and inst_out/inst_fault after edge N (1-cycle latency).
REQ-028 inst_out/inst_fault SHALL hold stable while inst_valid=1 and inst_ready=0.
REQ-029 inst_valid SHALL clear on inst_ready=1 when no new fetch is accepted in the same cycle; back-to-back fetches SHALL sustain 1 instruction/cycle.
REQ-030 Memory contents SHALL NOT be cleared by reset or load_start; only written words change.

Reset
REQ-031 On reset the block SHALL set state=LOAD, wptr=0, loaded_words=0, inst_valid=0, inst_out=0 and inst_fault=0 immediately, without waiting for clk.
REQ-032 A reset mid-load SHALL restart loading at word 0.

Configuration
REQ-033 The macro INST_FETCH_MEM_FAULT_EN SHALL control fault detection.
REQ-034 With INST_FETCH_MEM_FAULT_EN defined, inst_fault SHALL be 1 when addr[1:0]!=0, word index>=DEPTH, or word index>=loaded_words, and inst_out SHALL equal NOP_WORD on a fault.
REQ-035 Without INST_FETCH_MEM_FAULT_EN, inst_fault SHALL be tied to 0, addr[1:0] SHALL be ignored, and the index SHALL wrap modulo DEPTH.

Verification
REQ-036 Verification SHALL cover load: reset, load 4 beats 0x11,0x22,0x33,0x44 with last on the 4th -> loaded_words=4, RUN, load_ready=0.
REQ-037 Verification SHALL cover fetch: base=4, off=4 -> inst_valid next cycle, inst_out=0x33, inst_fault=0; back-to-back offsets 0,4,8 -> 0x11,0x22,0x33 on consecutive cycles.
REQ-038 Verification SHALL cover backpressure: inst_ready=0 for 3 cycles -> fetch_ready=0, inst_out held; release -> next fetch accepted.
REQ-039 Verification SHALL cover faults with FAULT_EN: base=2 -> fault=1, inst_out=0x00000013; base=16 (index 4>=loaded 4) -> fault=1. Without FAULT_EN: base=2 -> 0x11, fault=0.
REQ-040 Verification SHALL cover a collision: load_start together with fetch_valid -> fetch not accepted, LOAD next cycle, inst_valid=0.
REQ-041 Verification SHALL cover async reset: assert reset mid-load between edges -> outputs zero immediately; reload restarts at word 0; a beat with DEPTH=16 and no load_last -> RUN after 16 beats.
